// File: rtl/baggage_drop_pkg.sv
// Shared types and constants for the baggage-drop sequencer and display/drop datapath.
package baggage_drop_pkg;

  localparam int T_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    ARM     = 3'd3,
    DROP    = 3'd4,
    REJECT  = 3'd5,
    FAULT   = 3'd6
  } drop_state_t;

  // Seven-segment glyphs, segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam logic [6:0] SEG_DASH  = 7'b100_0000;
  localparam logic [6:0] SEG_H     = 7'b111_0110;
  localparam logic [6:0] SEG_O     = 7'b011_1111;
  localparam logic [6:0] SEG_T     = 7'b111_1000;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b011_1111, 7'b000_0110, 7'b101_1011, 7'b100_1111, 7'b110_0110,
    7'b110_1101, 7'b111_1101, 7'b000_0111, 7'b111_1111, 7'b110_1111
  };

endpackage

// File: rtl/sample_averager.sv
// Accumulates 2^AVG_LOG2 qualified samples; done/avg are valid combinationally
// in the cycle the final sample arrives so the caller can register the result.
module sample_averager
  import baggage_drop_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           sample_valid,
  input  logic [T_W-1:0] sample_data,
  output logic           done,
  output logic [T_W-1:0] avg
);

  localparam int AW = T_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [CW-1:0] cnt;

  assign acc_sum = acc + AW'(sample_data);
  assign done    = sample_valid && (cnt == CW'((1 << AVG_LOG2) - 1));
  assign avg     = T_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/drop_sequencer.sv
// Bag detect / settle / measure / arm / drop controller driving the display-and-drop datapath.
// Handshake: sample_valid is a one-cycle qualifier with no back-pressure; drop_done is a one-cycle pulse.
module drop_sequencer
  import baggage_drop_pkg::*;
#(
  parameter int           SETTLE_CYCLES = 16,
  parameter int           AVG_LOG2      = 2,
  parameter int           DROP_TIMEOUT  = 1024,
  parameter logic [T_W-1:0] T_LIM_RST   = 16'd500
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bag_present,
  input  logic           sensor_valid,
  input  logic [T_W-1:0] sensor_data,
  input  logic           cfg_we,
  input  logic [T_W-1:0] cfg_t_lim,
  input  logic           drop_activated,
  input  logic           drop_done,
  input  logic           fault_clr,
  output logic [T_W-1:0] t_act,
  output logic [T_W-1:0] t_lim,
  output logic           drop_en,
  output logic           busy,
  output logic           fault,
  output drop_state_t    dbg_state
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W    = $clog2(DROP_TIMEOUT + 1);

  drop_state_t   state, next_state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TMR_W-1:0]    drop_timer;
  logic [T_W-1:0]      t_act_q, t_lim_q;
  logic                avg_clr, avg_valid, avg_done;
  logic [T_W-1:0]      avg;

  // A sample coinciding with the bag leaving is discarded.
  assign avg_valid = (state == MEASURE) && bag_present && sensor_valid;

  sample_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (avg_clr),
    .sample_valid (avg_valid),
    .sample_data  (sensor_data),
    .done         (avg_done),
    .avg          (avg)
  );

  always_comb begin
    next_state = state;
    avg_clr    = 1'b0;
    case (state)
      IDLE:    if (bag_present) next_state = SETTLE;
      SETTLE: begin
        if (!bag_present) next_state = IDLE;
        else if (settle_cnt == '0) begin
          next_state = MEASURE;
          avg_clr    = 1'b1;
        end
      end
      MEASURE: begin
        if (!bag_present) next_state = IDLE;
        else if (avg_done) next_state = ARM;
      end
      ARM:     next_state = drop_activated ? DROP : REJECT;
      // drop_done takes priority over a coincident timeout.
      DROP: begin
        if (drop_done) next_state = IDLE;
        else if (drop_timer == TMR_W'(DROP_TIMEOUT - 1)) next_state = FAULT;
      end
      REJECT:  if (!bag_present) next_state = IDLE;
      FAULT:   if (fault_clr) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      drop_timer <= '0;
      t_act_q    <= '0;
      t_lim_q    <= T_LIM_RST;
    end else begin
      state <= next_state;
      if (state == IDLE && cfg_we) t_lim_q <= cfg_t_lim;
      if (state == IDLE && bag_present) settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
      if (state == DROP) drop_timer <= drop_timer + TMR_W'(1);
      else drop_timer <= '0;
      if (state == MEASURE && avg_done) t_act_q <= avg;
    end
  end

  assign t_act     = t_act_q;
  assign t_lim     = t_lim_q;
  assign drop_en   = (state == ARM) || (state == DROP) || (state == REJECT);
  assign busy      = (state != IDLE) && (state != FAULT);
  assign fault     = (state == FAULT);
  assign dbg_state = state;

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer with a behavioural averaging/accept model.
module tb_drop_sequencer;
  import baggage_drop_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bag_present, sensor_valid, cfg_we, drop_done, fault_clr;
  logic [15:0] sensor_data, cfg_t_lim;
  logic        drop_activated;
  logic [15:0] t_act, t_lim;
  logic        drop_en, busy, fault;
  drop_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  // combinational display/drop datapath: "Hot" when the measurement exceeds the limit
  assign drop_activated = drop_en && (t_act <= t_lim);

  drop_sequencer #(
    .SETTLE_CYCLES(16), .AVG_LOG2(2), .DROP_TIMEOUT(1024), .T_LIM_RST(16'd500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bag_present(bag_present), .sensor_valid(sensor_valid),
    .sensor_data(sensor_data), .cfg_we(cfg_we), .cfg_t_lim(cfg_t_lim),
    .drop_activated(drop_activated), .drop_done(drop_done), .fault_clr(fault_clr),
    .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en), .busy(busy), .fault(fault),
    .dbg_state(dbg_state)
  );

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bag_present = 0; sensor_valid = 0; sensor_data = 0;
    cfg_we = 0; cfg_t_lim = 0; drop_done = 0; fault_clr = 0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  // bag seen in IDLE (cycle 0) plus 16 settle cycles: leaves the bench at the first MEASURE cycle
  task automatic bag_to_measure;
    bag_present = 1;
    repeat (17) tick();
  endtask

  task automatic feed(input logic [15:0] d);
    sensor_valid = 1; sensor_data = d;
    tick();
    sensor_valid = 0;
  endtask

  task automatic wait_drop_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (drop_en) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (t_act !== 16'd0) begin failures++; $display("FAIL reset_t_act got=%0d exp=0", t_act); end
    checks++; if (t_lim !== 16'd500) begin failures++; $display("FAIL reset_t_lim got=%0d exp=500", t_lim); end
    checks++; if ({drop_en, busy, fault} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {drop_en, busy, fault}); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_settle_abort;
    bit seen;
    bag_present = 1;
    repeat (8) tick();
    bag_present = 0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL settle_abort_busy got=%b exp=0", busy); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (drop_en) seen = 1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL settle_abort_drop_en got=%b exp=0", seen); end
    checks++; if (t_act !== 16'd0) begin failures++; $display("FAIL settle_abort_t_act got=%0d exp=0", t_act); end
  endtask

  task automatic test_normal_drop;
    logic [15:0] exp_v;
    exp_q.push_back(16'((400 + 410 + 420 + 430) / 4));
    bag_to_measure();
    feed(400); feed(410); feed(420);
    checks++; if (drop_en !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", drop_en); end
    feed(430);
    exp_v = exp_q.pop_front();
    checks++; if (drop_en !== 1'b1) begin failures++; $display("FAIL latency_cycle21 got=%b exp=1", drop_en); end
    checks++; if (t_act !== exp_v) begin failures++; $display("FAIL normal_t_act got=%0d exp=%0d", t_act, exp_v); end
    tick();
    repeat (9) tick();
    checks++; if (drop_en !== 1'b1) begin failures++; $display("FAIL normal_drop_hold got=%b exp=1", drop_en); end
    drop_done = 1; tick(); drop_done = 0;
    checks++; if ({drop_en, busy} !== 2'b00) begin failures++; $display("FAIL normal_done got=%b exp=00", {drop_en, busy}); end
    bag_present = 0; tick();
  endtask

  task automatic test_hot_reject;
    bag_to_measure();
    repeat (4) feed(600);
    checks++; if (drop_en !== 1'b1 || t_act !== 16'd600) begin failures++; $display("FAIL hot_arm got=%b/%0d exp=1/600", drop_en, t_act); end
    tick();
    drop_done = 1; tick(); drop_done = 0;
    repeat (5) tick();
    checks++; if (drop_en !== 1'b1) begin failures++; $display("FAIL hot_hold got=%b exp=1", drop_en); end
    bag_present = 0; tick();
    checks++; if ({drop_en, busy} !== 2'b00) begin failures++; $display("FAIL hot_release got=%b exp=00", {drop_en, busy}); end
  endtask

  task automatic test_timeout;
    bag_to_measure();
    repeat (4) feed(100);
    bag_present = 0;
    tick();
    repeat (1023) tick();
    checks++; if ({fault, drop_en} !== 2'b01) begin failures++; $display("FAIL timeout_early got=%b exp=01", {fault, drop_en}); end
    tick();
    checks++; if ({fault, drop_en, busy} !== 3'b100) begin failures++; $display("FAIL timeout_fault got=%b exp=100", {fault, drop_en, busy}); end
    cfg_we = 1; cfg_t_lim = 16'd123; tick(); cfg_we = 0;
    checks++; if (t_lim !== 16'd500 || fault !== 1'b1) begin failures++; $display("FAIL fault_cfg got=%0d/%b exp=500/1", t_lim, fault); end
    fault_clr = 1; tick(); fault_clr = 0;
    checks++; if ({fault, busy} !== 2'b00) begin failures++; $display("FAIL fault_clr got=%b exp=00", {fault, busy}); end
    // drop_done in the very cycle the timeout would fire
    bag_to_measure();
    repeat (4) feed(100);
    bag_present = 0;
    tick();
    repeat (1023) tick();
    drop_done = 1; tick(); drop_done = 0;
    checks++; if ({fault, drop_en, busy} !== 3'b000) begin failures++; $display("FAIL timeout_race got=%b exp=000", {fault, drop_en, busy}); end
  endtask

  task automatic test_config_gating;
    bag_to_measure();
    cfg_we = 1; cfg_t_lim = 16'd300;
    feed(10);
    cfg_we = 0;
    checks++; if (t_lim !== 16'd500) begin failures++; $display("FAIL cfg_measure got=%0d exp=500", t_lim); end
    bag_present = 0; tick();
    cfg_we = 1; cfg_t_lim = 16'd300; tick(); cfg_we = 0;
    checks++; if (t_lim !== 16'd300) begin failures++; $display("FAIL cfg_idle got=%0d exp=300", t_lim); end
    cfg_we = 1; cfg_t_lim = 16'd500; tick(); cfg_we = 0;
  endtask

  task automatic test_async_reset;
    bag_to_measure();
    repeat (4) feed(100);
    tick();
    checks++; if (drop_en !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", drop_en); end
    #2 rst_n = 0;
    #1;
    checks++; if ({drop_en, busy, fault} !== 3'b000 || t_act !== 16'd0 || t_lim !== 16'd500) begin
      failures++; $display("FAIL areset_outputs got=%b/%0d/%0d exp=000/0/500", {drop_en, busy, fault}, t_act, t_lim);
    end
    idle_inputs();
    @(posedge clk); #1 rst_n = 1;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [15:0] s, lim, exp_v;
    int unsigned sum;
    bit accept, ok;
    for (int it = 0; it < 16; it++) begin
      lim = 16'($urandom_range(0, 1000));
      cfg_we = 1; cfg_t_lim = lim; tick(); cfg_we = 0;
      bag_to_measure();
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        s = 16'($urandom_range(0, 1200));
        sum += s;
        feed(s);
      end
      exp_q.push_back(16'(sum / 4));
      accept = ((sum / 4) <= lim);
      wait_drop_en(ok);
      exp_v = exp_q.pop_front();
      checks++; if (ok !== 1'b1 || t_act !== exp_v) begin failures++; $display("FAIL rand_t_act it=%0d got=%0d exp=%0d en=%b", it, t_act, exp_v, ok); end
      tick();
      repeat ($urandom_range(0, 5)) tick();
      drop_done = 1; tick(); drop_done = 0;
      checks++; if (drop_en !== !accept) begin failures++; $display("FAIL rand_decision it=%0d got=%b exp=%b", it, drop_en, !accept); end
      bag_present = 0; tick();
      checks++; if ({drop_en, busy} !== 2'b00) begin failures++; $display("FAIL rand_release it=%0d got=%b exp=00", it, {drop_en, busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_settle_abort();
    test_normal_drop();
    test_hot_reject();
    test_timeout();
    test_config_gating();
    test_async_reset();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drop_sequencer.md
# drop_sequencer

Sequential controller for the baggage-drop display/drop datapath. It detects a bag, waits for it to settle, averages sensor samples into `t_act`, holds the configured limit `t_lim`, and asserts `drop_en`. It then uses the datapath's `drop_activated` feedback to run the drop, or holds the "Hot" rejection. It sits between the sensor/drop mechanism and the combinational display-and-drop block, whose `t_act`, `t_lim` and `drop_en` inputs it drives.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16: cycles `bag_present` must stay high before measuring (≥1).
- `AVG_LOG2`, default 2: log2 of the number of averaged samples (0..4).
- `DROP_TIMEOUT`, default 1024: maximum cycles to wait for `drop_done` (≥1).
- `T_LIM_RST`, default 16'd500: reset value of `t_lim`.

Ports:
- `clk` input 1: sole clock; everything is sampled on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `bag_present` input 1: level from the bag sensor.
- `sensor_valid` input 1: qualifies `sensor_data` for one cycle.
- `sensor_data` input 16: unsigned measurement sample.
- `cfg_we` input 1: write strobe for `cfg_t_lim`; honoured only in IDLE.
- `cfg_t_lim` input 16: new limit value.
- `drop_activated` input 1: feedback from the display/drop datapath.
- `drop_done` input 1: single-cycle pulse from the mechanism when the drop has finished.
- `fault_clr` input 1: clears FAULT.
- `t_act` output 16: registered averaged measurement.
- `t_lim` output 16: registered limit.
- `drop_en` output 1: registered enable to the datapath.
- `busy` output 1: high in every state except IDLE and FAULT.
- `fault` output 1: high in FAULT.

## Operation
- Reset values: state IDLE, `t_act` 0, `t_lim` `T_LIM_RST`, `drop_en` 0, `busy` 0, `fault` 0. All counters and the accumulator reset to 0.
- IDLE:
  - `cfg_we` loads `t_lim` at the next edge.
  - When `bag_present` is 1, go to SETTLE and load the settle counter with `SETTLE_CYCLES-1`.
- SETTLE: decrement each cycle.
  - If `bag_present` is 0, go to IDLE.
  - When the counter reaches 0 with `bag_present` high, go to MEASURE and clear the accumulator and the sample count.
- MEASURE:
  - Each `sensor_valid` cycle adds `sensor_data` to an accumulator of width 16+`AVG_LOG2`. This width cannot overflow.
  - After 2^`AVG_LOG2` samples, `t_act` ← `acc >> AVG_LOG2` (truncating) at the same edge as the move to ARM.
  - If `bag_present` falls, go to IDLE with `t_act` unchanged. A sample arriving in that same cycle is discarded.
- ARM: lasts exactly one cycle with `drop_en`=1. Sample `drop_activated`:
  - 1 → DROP.
  - 0 → REJECT (the datapath shows "Hot").
- DROP:
  - `drop_en` stays 1 and the timeout counter increments.
  - `drop_done` → IDLE with `drop_en` 0.
  - Counter reaching `DROP_TIMEOUT` without `drop_done` → FAULT.
  - If `drop_done` and the timeout occur in the same cycle, `drop_done` wins.
  - `bag_present` is ignored in DROP.
- REJECT: `drop_en` stays 1 until `bag_present` is 0, then go to IDLE.
- FAULT:
  - `drop_en` 0 and `fault` 1.
  - `fault_clr` → IDLE.
  - `cfg_we` is ignored.
- `cfg_we` outside IDLE is dropped silently; `t_lim` is never modified mid-sequence.
- `fault_clr` outside FAULT has no effect.

## Timing
- `drop_en` is driven from the registered state and is 1 exactly in ARM, DROP and REJECT.
- The datapath is combinational, so `drop_activated` is valid in the same cycle `drop_en` rises. ARM samples it at the end of that cycle.
- Latency from the first `bag_present` high cycle in IDLE to `drop_en`=1 is 1 + `SETTLE_CYCLES` + the MEASURE duration. With samples on every cycle, MEASURE lasts 2^`AVG_LOG2` cycles; for the defaults the total is 1 + 16 + 4 = 21 cycles.
- `drop_en` falls at the edge that registers `drop_done`.
- When `rst_n` is asserted mid-sequence, all outputs go to their reset values immediately (asynchronously), and `drop_en` drops without waiting for `drop_done`.

## Structure
- Package `baggage_drop_pkg` holds:
  - the width constant `T_W`=16;
  - the state enum `drop_state_t` (IDLE, SETTLE, MEASURE, ARM, DROP, REJECT, FAULT);
  - the shared seven-segment glyph constants, which are also used by the display block.
- One sub-module, `sample_averager`, contains the accumulator, the sample counter and the shift. Its interface is `clr`, `sample_valid`, `sample_data`, `done` (one-cycle pulse) and `avg`.
- The FSM, settle counter, timeout counter and `t_lim` register live in `drop_sequencer`.

## Test plan
- **Normal drop** (defaults): `t_lim`=500, bag held, four samples 400/410/420/430, datapath model returns `drop_activated`=1 → `t_act`=415, `drop_en` rises at cycle 21, `drop_done` after 10 cycles → IDLE, `drop_en`=0 the following cycle.
- **Hot reject**: samples all 600, `t_lim`=500 → ARM sees `drop_activated`=0, REJECT holds `drop_en`=1 until `bag_present` falls, then IDLE.
- **Bag lost in SETTLE**: `bag_present` drops at settle cycle 8 → IDLE, `t_act` unchanged (0 after reset), `drop_en` never rises.
- **Timeout**: `drop_done` never arrives → `fault`=1 exactly `DROP_TIMEOUT` cycles after entering DROP, `drop_en`=0; `fault_clr` → IDLE. Also: `drop_done` in the timeout cycle → IDLE with no fault.
- **Config gating**: `cfg_we` with 300 during MEASURE → `t_lim` stays 500; the same write in IDLE → `t_lim`=300 next cycle.
- **Async reset**: `rst_n` low during DROP → `drop_en`, `busy` and `t_act` read 0 and `t_lim` reads 500 before the next clock edge.
